crop_frame_streamer: RTL

- Downstream reader for the 28x28 cropped/downsampled camera image.
- Collects the 784 8-bit samples emitted by the crop stage into a local frame buffer.
- On request, streams the frame out byte by byte over a valid/ready interface to the SPART transmitter, which sends it to the NN host.
- Sits between the crop stage and the SPART TX.

---
 rtl/crop_pkg.sv | 22 ++
 rtl/crop_frame_ram.sv | 24 ++
 rtl/crop_frame_streamer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/crop_pkg.sv
// Shared constants and state type for the 28x28 crop frame streamer.
package crop_pkg;

  localparam int unsigned IMG_W = 28;
  localparam int unsigned IMG_H = 28;
  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned IDX_W = 10;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

  // Sync header emitted ahead of the pixels when the header option is built in.
  localparam logic [7:0] HDR0 = 8'hA5;
  localparam logic [7:0] HDR1 = 8'h5A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2,
    SEND = 2'd3
  } crop_state_e;

endpackage

// File: rtl/crop_frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port (1-cycle latency).
module crop_frame_ram #(
  parameter int unsigned Depth = 784,
  parameter int unsigned Width = 8,
  parameter int unsigned AddrW = 10
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/crop_frame_streamer.sv
// Buffers one 28x28 cropped frame and streams it byte by byte to the SPART transmitter.
// Define CROP_SYNC_HDR_EN to prefix each streamed frame with the 0xA5 0x5A sync header.
module crop_frame_streamer
  import crop_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iSOF,
  input  logic          iDVAL,
  input  logic [DW-1:0] iDATA,
  input  logic          iSTART,
  output logic [DW-1:0] oTX_DATA,
  output logic          oTX_VALID,
  input  logic          iTX_READY,
  output logic          oFRAME_RDY,
  output logic          oBUSY
);

  crop_state_e      state_q, state_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             pend_q, pend_d;
  logic [DW-1:0]    tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             frame_rdy_q;
  logic             busy_q;
  logic             ram_we;
  logic [DW-1:0]    ram_rdata;
`ifdef CROP_SYNC_HDR_EN
  logic [1:0]       hdr_left_q, hdr_left_d;
`endif

  // Read address follows the next-state index so the byte is ready one cycle later.
  crop_frame_ram #(
    .Depth(NPIX),
    .Width(DW),
    .AddrW(IDX_W)
  ) u_ram (
    .clk_i  (iCLK),
    .we_i   (ram_we),
    .waddr_i(wr_idx_q),
    .wdata_i(iDATA),
    .raddr_i(rd_idx_d),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    pend_d     = pend_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    ram_we     = 1'b0;
`ifdef CROP_SYNC_HDR_EN
    hdr_left_d = hdr_left_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (iSOF) begin
          state_d  = FILL;
          wr_idx_d = '0;
        end
      end
      FILL: begin
        // A start-of-frame in the same cycle as a sample drops that sample.
        if (iSOF) begin
          wr_idx_d = '0;
        end else if (iDVAL) begin
          ram_we = 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            state_d = FULL;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end
      FULL: begin
        if (iSTART) begin
          state_d  = SEND;
          rd_idx_d = '0;
          pend_d   = 1'b1;
`ifdef CROP_SYNC_HDR_EN
          hdr_left_d = 2'd2;
`endif
        end
      end
      SEND: begin
        if (pend_q) begin
          pend_d     = 1'b0;
          tx_valid_d = 1'b1;
`ifdef CROP_SYNC_HDR_EN
          if (hdr_left_q == 2'd2) begin
            tx_data_d = DW'(HDR0);
          end else if (hdr_left_q == 2'd1) begin
            tx_data_d = DW'(HDR1);
          end else begin
            tx_data_d = ram_rdata;
          end
`else
          tx_data_d = ram_rdata;
`endif
        end else if (tx_valid_q && iTX_READY) begin
          tx_valid_d = 1'b0;
`ifdef CROP_SYNC_HDR_EN
          if (hdr_left_q != 2'd0) begin
            hdr_left_d = hdr_left_q - 2'd1;
            pend_d     = 1'b1;
          end else
`endif
          if (rd_idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
            pend_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q     <= IDLE;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      pend_q      <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      frame_rdy_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef CROP_SYNC_HDR_EN
      hdr_left_q  <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      pend_q      <= pend_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      frame_rdy_q <= (state_d == FULL) || (state_d == SEND);
      busy_q      <= (state_d == FILL) || (state_d == SEND);
`ifdef CROP_SYNC_HDR_EN
      hdr_left_q  <= hdr_left_d;
`endif
    end
  end

  assign oTX_DATA   = tx_data_q;
  assign oTX_VALID  = tx_valid_q;
  assign oFRAME_RDY = frame_rdy_q;
  assign oBUSY      = busy_q;

endmodule
